// File: rtl/rr_mux_4_1_arbiter.sv
// Round-robin arbiter feeding a registered 4:1 mux that shares one valid/ready output channel.
// Define RR_MUX_4_1_ARBITER_STATS_EN to add saturating per-requester grant counters.
module rr_mux_4_1_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
`ifdef RR_MUX_4_1_ARBITER_STATS_EN
  output logic [7:0]   grant_cnt0,
  output logic [7:0]   grant_cnt1,
  output logic [7:0]   grant_cnt2,
  output logic [7:0]   grant_cnt3,
`endif
  output logic [1:0]   out_sel
);

  logic [1:0]   ptr;
  logic         can_load;
  logic         grant_found;
  logic [1:0]   grant_idx;
  logic [1:0]   cand;
  logic         load;
  logic [W-1:0] grant_data;

  // Search ptr, ptr+1, ... with natural 2-bit wrap; first valid index wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr;
    cand        = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    grant_data = d0;
      2'd1:    grant_data = d1;
      2'd2:    grant_data = d2;
      default: grant_data = d3;
    endcase
  end

  // A full register may drain and reload in the same cycle.
  assign can_load = !out_valid || out_ready;
  assign load     = can_load && grant_found;
  assign in_ready = (load && !rst) ? (4'b0001 << grant_idx) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd0;
    end else if (can_load) begin
      if (grant_found) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_idx;
        ptr       <= grant_idx + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_4_1_ARBITER_STATS_EN
  logic [7:0] cnt [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= 8'd0;
      end
    end else if (load && (cnt[grant_idx] != 8'hFF)) begin
      cnt[grant_idx] <= cnt[grant_idx] + 8'd1;
    end
  end

  assign grant_cnt0 = cnt[0];
  assign grant_cnt1 = cnt[1];
  assign grant_cnt2 = cnt[2];
  assign grant_cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_rr_mux_4_1_arbiter.sv
// Self-checking bench for rr_mux_4_1_arbiter: vector table, corner sequences and random traffic
// checked against a rule-level model of the arbiter.
module tb_rr_mux_4_1_arbiter;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [W-1:0] d0, d1, d2, d3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
`ifdef RR_MUX_4_1_ARBITER_STATS_EN
  logic [7:0]   grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3;
`endif

  rr_mux_4_1_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef RR_MUX_4_1_ARBITER_STATS_EN
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
    .grant_cnt2(grant_cnt2),
    .grant_cnt3(grant_cnt3),
`endif
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the output word and the next-highest-priority requester.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  int           m_cnt [4];

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_sel;
    logic [3:0] exp_data;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  function automatic int model_grant(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    end
    return -1;
  endfunction

  // Apply one cycle of stimulus from a negedge; check in_ready before the edge, outputs after it.
  task automatic cycle(input logic [3:0] v, input logic rdy, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] e,
                       output logic [3:0] ready_seen);
    logic [W-1:0] dv [4];
    logic [3:0]   exp_rdy;
    int           g;
    bit           can_load;
    in_valid  = v;
    out_ready = rdy;
    d0 = a; d1 = b; d2 = c; d3 = e;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = e;
    #1;
    can_load = !m_valid || rdy;
    g        = model_grant(v);
    exp_rdy  = (can_load && g >= 0) ? 4'(1 << g) : 4'b0000;
    ready_seen = in_ready;
    check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (can_load) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = dv[g];
        m_sel   = g;
        m_ptr   = (g + 1) % 4;
        if (m_cnt[g] < 255) m_cnt[g]++;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_data", {28'd0, out_data}, {28'd0, m_data});
    check("out_sel", {30'd0, out_sel}, 32'(m_sel));
`ifdef RR_MUX_4_1_ARBITER_STATS_EN
    check("grant_cnt0", {24'd0, grant_cnt0}, 32'(m_cnt[0]));
    check("grant_cnt1", {24'd0, grant_cnt1}, 32'(m_cnt[1]));
    check("grant_cnt2", {24'd0, grant_cnt2}, 32'(m_cnt[2]));
    check("grant_cnt3", {24'd0, grant_cnt3}, 32'(m_cnt[3]));
`endif
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rs;

    tbl = '{
      '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA},
      '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB},
      '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC},
      '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD},
      '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA},
      '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB},
      '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC},
      '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD},
      '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hC},  // ptr -> 3
      '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA},  // skip 3, wrap to 0
      '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB},
      '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'hB},  // idle drain holds data/sel
      '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 4'hD},  // empty register loads despite !out_ready
      '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 4'hD},  // stalled
      '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA},
      '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB},
      '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB}   // lone requester wins again
    };

    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {28'd0, out_data}, 32'd0);
    check("reset_out_sel", {30'd0, out_sel}, 32'd0);
    check("reset_in_ready", {28'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].rdy, 4'hA, 4'hB, 4'hC, 4'hD, rs);
      check($sformatf("vec%0d_ready", i), {28'd0, rs}, {28'd0, tbl[i].exp_ready});
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      check($sformatf("vec%0d_sel", i), {30'd0, out_sel}, {30'd0, tbl[i].exp_sel});
      check($sformatf("vec%0d_data", i), {28'd0, out_data}, {28'd0, tbl[i].exp_data});
    end

    // Backpressure: word 5 from requester 2 held for three stalled cycles.
    cycle(4'b0100, 1'b1, 4'hA, 4'hB, 4'h5, 4'hD, rs);
    check("bp_load_data", {28'd0, out_data}, 32'h5);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 1'b0, 4'hA, 4'hB, 4'h7, 4'hD, rs);
      check("bp_stall_ready", {28'd0, rs}, 32'h0);
      check("bp_stall_data", {28'd0, out_data}, 32'h5);
    end
    cycle(4'b0100, 1'b1, 4'hA, 4'hB, 4'h7, 4'hD, rs);
    check("bp_release_ready", {28'd0, rs}, 32'h4);
    check("bp_release_data", {28'd0, out_data}, 32'h7);
    cycle(4'b1111, 1'b1, 4'hA, 4'hB, 4'hC, 4'hD, rs);
    check("bp_ptr_kept", {30'd0, out_sel}, 32'd3);

    // Asynchronous reset between edges with a valid word pending.
    in_valid = 4'b1111;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data", {28'd0, out_data}, 32'd0);
    check("async_rst_sel", {30'd0, out_sel}, 32'd0);
    check("async_rst_ready", {28'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(4'b1111, 1'b1, 4'hA, 4'hB, 4'hC, 4'hD, rs);
    check("post_rst_grant", {28'd0, rs}, 32'h1);

    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), rs);
    end

`ifdef RR_MUX_4_1_ARBITER_STATS_EN
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(4'b0010, 1'b1, 4'hA, 4'hB, 4'hC, 4'hD, rs);
    end
    check("stats_cnt1_sat", {24'd0, grant_cnt1}, 32'd255);
    check("stats_cnt0", {24'd0, grant_cnt0}, 32'd0);
    check("stats_cnt2", {24'd0, grant_cnt2}, 32'd0);
    check("stats_cnt3", {24'd0, grant_cnt3}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_4_1_arbiter.md
Name: rr_mux_4_1_arbiter

Overview:
- Round-robin arbiter plus registered 4:1 mux that shares one output channel among four valid/ready requesters.
- Sequences the 4:1 mux select each cycle, chooses the winner fairly and holds the result in an output register.
- Sits between four producers and a single consumer in the datapath.

Parameters:
W, 4, data width of every requester and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  bit i set = requester i offers data this cycle.
- in_ready  output  4  bit i set = requester i data accepted this cycle; one-hot or zero.
- d0, d1, d2, d3  input  W each  requester data.
- out_valid  output  1  output register holds a valid word.
- out_ready  input  1  consumer accepts the output word this cycle.
- out_data  output  W  registered winning data.
- out_sel  output  2  index of the requester whose data is in out_data.

Behaviour:
- State: output register (out_valid, out_data, out_sel) and a 2-bit round-robin pointer ptr. ptr is the highest-priority index for the next grant.
- Reset (rst=1, asynchronous): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is 0 while rst=1.
- can_load = !out_valid || out_ready. This is combinational, so a full register drains and reloads in the same cycle.
- Grant search is combinational. The winner g is the first index with in_valid set, searching ptr, ptr+1, ptr+2, ptr+3 with mod-4 wrap.
- in_ready[g]=1 only when can_load=1 and some in_valid bit is set. All other in_ready bits are 0.
- in_ready may depend combinationally on in_valid and out_ready. Requesters must not make in_valid depend on in_ready.
- Transfer on a clock edge when can_load=1 and g exists:
  - out_data <= d[g], out_sel <= g, out_valid <= 1.
  - ptr <= g+1 mod 4; after g=3, ptr becomes 0.
- can_load=1 and no in_valid bit set: out_valid <= 0. out_data and out_sel hold their values. ptr holds.
- can_load=0 (out_valid=1, out_ready=0): all registers hold; in_ready=0. The word is stable until accepted.
- Latency: requester handshake in cycle N, word visible on out_* in cycle N+1.
- Throughput: one word per cycle when out_ready is held high.
- Fairness: with all four requesters valid continuously, grants rotate 0,1,2,3,0,...
- A single valid requester wins every cycle regardless of ptr.
- Requesters may drop in_valid at any time without a handshake. This does not change ptr.
- Reset mid-transfer: the pending output word is discarded, out_valid=0 asynchronously, and ptr returns to 0.

Optional Feature:
- Macro RR_MUX_4_1_ARBITER_STATS_EN.
- Defined:
  - Adds output ports grant_cnt0, grant_cnt1, grant_cnt2, grant_cnt3, each 8 bits.
  - grant_cnti increments on every transfer where g=i.
  - Saturates at 255; does not wrap.
  - Reset value 0, cleared asynchronously by rst.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-simulation with out_valid=1, asynchronously between edges. Required: out_valid=0, out_data=0, out_sel=0 immediately; after release, first grant with in_valid=4'b1111 goes to 0.
- Rotation: in_valid=4'b1111, d0..d3=4'hA,4'hB,4'hC,4'hD, out_ready=1 for 8 cycles. Required: out_data sequence A,B,C,D,A,B,C,D, each one cycle after its in_ready; out_sel 0,1,2,3,...
- Skip and wrap: ptr=3 (after a grant to 2), in_valid=4'b0011. Required: grant to 0, then ptr=1. Next cycle grant to 1, then ptr=2.
- Backpressure: out_valid=1 holding 4'h5, out_ready=0 for 3 cycles, in_valid=4'b0100. Required:
  - in_ready=0, out_data=4'h5, ptr unchanged throughout.
  - out_ready=1 in cycle 4 gives in_ready=4'b0100 that cycle, and out_data=d2 the next cycle.
- Idle drain: single transfer, then in_valid=0, out_ready=1. Required: out_valid goes to 0 one cycle after acceptance; out_data and out_sel hold.
- Stats (macro defined): 300 consecutive grants to requester 1 only. Required: grant_cnt1=255 (saturated); grant_cnt0, grant_cnt2 and grant_cnt3 remain 0.
